// File: rtl/bean_pkg.sv
// rtl/bean_pkg.sv - shared fetch-stage constants and types
package bean_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order queue of {pc, instr} entries with synchronous clear
module fetch_fifo
    import bean_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  fetch_entry_t             i_wdata,
    output fetch_entry_t             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   r_mem [0:DEPTH-1];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    // Entry storage: written at the tail on push; data needs no reset
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // A push at full is only legal alongside a pop; anything else means the request logic overran us
    always_ff @(posedge clk) begin
        if (!reset && !i_clear) begin
            a_no_overflow: assert (!(i_push && !i_pop && r_count == CW'(DEPTH)));
        end
    end

    assign o_rdata = r_mem[r_head];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch stage with request FSM and in-order instruction queue
module fetch_buffer
    import bean_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_adrs,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rd,
    input  logic        stall_F,
    input  logic        flush_F,
    input  logic [31:0] pc_redirect,
    output logic [31:0] Instr,
    output logic [31:0] pc,
    output logic        instr_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_last_pc;

    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_b2b;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_less_pop;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;

    assign w_pop            = !w_empty && !stall_F && !flush_F;
    assign w_push           = (r_state == WAIT) && imem_rvalid && !flush_F;
    // w_pop implies non-empty, so this never underflows
    assign w_count_less_pop = w_count - CW'(w_pop);
    assign w_wdata          = '{pc: r_fetch_pc, instr: imem_rd};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush_F),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Request decode: a new request only when its response is guaranteed a free slot
    always_comb begin
        w_req = 1'b0;
        w_b2b = 1'b0;
        if (!reset && !flush_F) begin
            case (r_state)
                IDLE: w_req = !w_full || w_pop;
                WAIT: begin
                    w_b2b = imem_rvalid && (w_count_less_pop < CW'(DEPTH - 1));
                    w_req = w_b2b;
                end
                default: w_req = 1'b0;
            endcase
        end
    end

    assign imem_req  = w_req;
    assign imem_adrs = w_b2b ? (r_fetch_pc + 32'd4) : r_fetch_pc;

    // Fetch FSM, next fetch address and the PC shown while the queue is empty
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_last_pc  <= RESET_PC;
        end else if (flush_F) begin
            r_fetch_pc <= pc_redirect & ~32'd3;
            // An outstanding request turns stale; if its response lands now it is the one
            // being waited for, so DROP would never see another and we go straight to IDLE
            if (r_state != IDLE) begin
                r_state <= imem_rvalid ? IDLE : DROP;
            end
        end else begin
            if (w_pop) begin
                r_last_pc <= w_head.pc + 32'd4;
            end
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            case (r_state)
                IDLE: if (w_req) r_state <= WAIT;
                WAIT: if (imem_rvalid && !w_req) r_state <= IDLE;
                DROP: if (imem_rvalid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instr_valid = !w_empty;
    assign Instr       = w_empty ? NOP : w_head.instr;
    assign pc          = w_empty ? r_last_pc : w_head.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer with a variable-wait memory model
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_adrs;
    logic        imem_rvalid;
    logic [31:0] imem_rd;
    logic        stall_F;
    logic        flush_F;
    logic [31:0] pc_redirect;
    logic [31:0] Instr;
    logic [31:0] pc;
    logic        instr_valid;

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_adrs   (imem_adrs),
        .imem_rvalid (imem_rvalid),
        .imem_rd     (imem_rd),
        .stall_F     (stall_F),
        .flush_F     (flush_F),
        .pc_redirect (pc_redirect),
        .Instr       (Instr),
        .pc          (pc),
        .instr_valid (instr_valid)
    );

    typedef struct {
        logic [31:0] adr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    int          req_cyc[$];
    logic [31:0] exp_pc;
    int cyc, rel0, mem_wait;
    int n_out, n_req, viol, viol_base, n_req_base;
    int n_pops, first_pop, last_pop, n_extra;
    int n_tests, n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic run_drain(input string tag, input int budget);
        stall_F = 1'b0;
        for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
        stall_F = 1'b1;
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        check_eq({tag, "_extra_pops"}, n_extra, 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: responds in order, mem_wait idle cycles after the request cycle
    initial begin
        imem_rvalid = 1'b0;
        imem_rd     = 32'h0;
        n_out = 0; n_req = 0; viol = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rd     = mem_word(pend_q[0].adr);
                void'(pend_q.pop_front());
                n_out--;
            end else begin
                imem_rvalid = 1'b0;
                imem_rd     = 32'h0;
            end
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
                n_out = 0;
            end else if (imem_req) begin
                pend_t p;
                if (n_out > 0) viol++;
                p.adr = imem_adrs;
                p.due = cyc + 1 + mem_wait;
                pend_q.push_back(p);
                n_out++;
                n_req++;
                req_cyc.push_back(cyc);
            end
        end
    end

    // Scoreboard: each pop is compared against the next expected PC and its memory word
    initial begin
        n_pops = 0; first_pop = 0; last_pop = 0; n_extra = 0;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && !stall_F && !flush_F) begin
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    exp_pc = exp_q.pop_front();
                    check_eq("pop_pc", pc, exp_pc);
                    check_eq("pop_instr", Instr, mem_word(exp_pc));
                    if (n_pops == 0) first_pop = cyc;
                    last_pop = cyc;
                    n_pops++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; stall_F = 1'b1; flush_F = 1'b0; pc_redirect = 32'h0; mem_wait = 0;

        // Reset values and zero-wait streaming
        repeat (3) step();
        sample();
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr", Instr, NOP);
        check_eq("rst_pc", pc, RESET_PC);
        for (int i = 0; i < 16; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        n_pops = 0;
        step(); reset = 1'b0; stall_F = 1'b0; rel0 = cyc;
        sample();
        check_eq("c0_req", imem_req, 1);
        check_eq("c0_adrs", imem_adrs, RESET_PC);
        check_eq("c0_valid", instr_valid, 0);
        step(); sample();
        check_eq("c1_req", imem_req, 1);
        check_eq("c1_adrs", imem_adrs, RESET_PC + 32'd4);
        check_eq("c1_valid", instr_valid, 0);
        step(); sample();
        check_eq("c2_valid", instr_valid, 1);
        run_drain("stream", 40);
        check_eq("stream_first_lat", first_pop - rel0, 2);
        check_eq("stream_burst_cycles", last_pop - first_pop, 15);

        // Stall for 10 cycles: queue fills to DEPTH, requests stop, head holds
        step(); reset = 1'b1; stall_F = 1'b1; mem_wait = 0;
        repeat (2) step();
        n_req_base = n_req; reset = 1'b0;
        repeat (9) begin sample(); step(); end
        sample();
        check_eq("stall_req", imem_req, 0);
        check_eq("stall_nreq", n_req - n_req_base, DEPTH);
        check_eq("stall_valid", instr_valid, 1);
        check_eq("stall_head_pc", pc, 32'h0);
        check_eq("stall_head_instr", Instr, mem_word(32'h0));
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        step(); stall_F = 1'b0;
        sample();
        check_eq("resume_req", imem_req, 1);
        check_eq("resume_adrs", imem_adrs, 32'h10);
        run_drain("stall", 40);

        // Three wait cycles: one request every four cycles, never while waiting
        step(); reset = 1'b1; stall_F = 1'b1; mem_wait = 3;
        repeat (2) step();
        req_cyc.delete(); viol_base = viol; n_pops = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
        reset = 1'b0; rel0 = cyc;
        run_drain("lat3", 60);
        check_eq("lat3_first_lat", first_pop - rel0, 5);
        check_eq("lat3_busy_req", viol - viol_base, 0);
        check_eq("lat3_nreq_ge3", 32'(req_cyc.size() >= 3), 1);
        if (req_cyc.size() >= 3) begin
            check_eq("lat3_gap1", req_cyc[1] - req_cyc[0], 4);
            check_eq("lat3_gap2", req_cyc[2] - req_cyc[1], 4);
        end

        // Flush while a request is outstanding: stale word dropped, refetch at redirect
        step(); reset = 1'b1; stall_F = 1'b1; mem_wait = 0;
        repeat (2) step();
        reset = 1'b0;
        sample(); step(); mem_wait = 3;
        sample();
        check_eq("fl_c1_adrs", imem_adrs, 32'h4);
        step(); sample();
        check_eq("fl_pre_valid", instr_valid, 1);
        step(); flush_F = 1'b1; pc_redirect = 32'h0000_0101;
        sample();
        check_eq("fl_req_blocked", imem_req, 0);
        step(); flush_F = 1'b0; pc_redirect = 32'h0;
        sample();
        check_eq("fl_emptied", instr_valid, 0);
        check_eq("fl_drop_req", imem_req, 0);
        step(); sample();
        check_eq("fl_stale_req", imem_req, 0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        step(); sample();
        check_eq("fl_stale_dropped", instr_valid, 0);
        check_eq("fl_redirect_req", imem_req, 1);
        check_eq("fl_redirect_adrs", imem_adrs, 32'h100);
        step();
        run_drain("flush", 60);

        // Flush coinciding with a response while stalled
        step(); reset = 1'b1; stall_F = 1'b1; mem_wait = 0;
        repeat (2) step();
        reset = 1'b0;
        sample(); step();
        sample(); step(); flush_F = 1'b1; pc_redirect = 32'h0000_0200;
        sample();
        check_eq("fr_req_blocked", imem_req, 0);
        step(); flush_F = 1'b0; pc_redirect = 32'h0;
        sample();
        check_eq("fr_emptied", instr_valid, 0);
        check_eq("fr_req", imem_req, 1);
        check_eq("fr_adrs", imem_adrs, 32'h200);
        for (int i = 0; i < 2; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        step();
        run_drain("flush_rv", 40);

        // Reset with three entries queued and a request outstanding
        step(); reset = 1'b1; stall_F = 1'b1; mem_wait = 0;
        repeat (2) step();
        reset = 1'b0;
        sample(); step();
        sample(); step();
        sample(); step(); mem_wait = 3;
        sample(); step();
        sample();
        check_eq("rs_pre_valid", instr_valid, 1);
        check_eq("rs_pre_pc", pc, 32'h0);
        step(); reset = 1'b1;
        sample();
        check_eq("rs_req_in_reset", imem_req, 0);
        step(); reset = 1'b0; mem_wait = 0;
        sample();
        check_eq("rs_valid", instr_valid, 0);
        check_eq("rs_instr", Instr, NOP);
        check_eq("rs_pc", pc, RESET_PC);
        check_eq("rs_req", imem_req, 1);
        check_eq("rs_adrs", imem_adrs, RESET_PC);
        for (int i = 0; i < 3; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
        step();
        run_drain("reset_mid", 60);

        check_eq("busy_req_total", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
